lat_memory: RTL and testbench
=============================

LAT_MEMORY -- requirements
Module: lat_memory

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width in bits (multiple of 8).
REQ-002 SHALL have parameter MEM_SIZE, default 1024, depth in XLEN-bit words (power of two).
REQ-003 SHALL have parameter LATENCY, default 3, cycles from request acceptance to response valid (>=1).
REQ-004 SHALL have parameter TAG_W, default 4, request tag width.
REQ-005 SHALL have ports:
  clk  in  1  sole clock, rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  req_valid  in  1  request present.
  req_ready  out  1  block can accept request.
  req_write  in  1  1=write, 0=read.
  req_addr  in  XLEN  byte address.
  req_wdata  in  XLEN  write data.
  req_be  in  XLEN/8  byte enables.
  req_tag  in  TAG_W  request tag, echoed.
  resp_valid  out  1  response present.
  resp_ready  in  1  consumer accepts response.
  resp_rdata  out  XLEN  read data (0 for writes/errors).
  resp_tag  out  TAG_W  tag of request being answered.
  resp_err  out  1  request misaligned or out of range.

Function
REQ-006 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE; one outstanding request.
REQ-007 SHALL assert req_ready only in IDLE; acceptance = req_valid && req_ready at a rising edge.
REQ-008 SHALL on acceptance latch write, addr, wdata, be, tag; enter BUSY with counter = LATENCY-1, or RESP directly when LATENCY==1.
REQ-009 SHALL decrement counter each BUSY cycle and enter RESP on the edge where counter reaches 0; resp_valid high exactly LATENCY cycles after the acceptance edge.
REQ-010 SHALL compute word index = addr[$clog2(MEM_SIZE)+1:2]; err = (addr[1:0]!=0) || (addr >= MEM_SIZE*4).
REQ-011 SHALL commit writes and capture read data on the edge entering RESP; err requests SHALL not modify the array and return rdata 0.
REQ-012 SHALL hold resp_valid, resp_rdata, resp_tag, resp_err stable in RESP until resp_valid && resp_ready, then return to IDLE next edge.
REQ-013 SHALL not accept a new request in the cycle the response handshakes (req_ready low in RESP); a read after a write to the same word SHALL return the written data.
REQ-014 SHALL ignore req_* inputs outside IDLE; changes do not affect the in-flight request.

Reset
REQ-015 SHALL, on rst_n low, immediately force state IDLE, counter 0, req_ready 0 while rst_n low, resp_valid 0, resp_rdata 0, resp_tag 0, resp_err 0.
REQ-016 SHALL abort any in-flight request on reset; no write commits for it.
REQ-017 SHALL not reset array contents (undefined until written); req_ready rises the first edge after rst_n deasserts.

Configuration
REQ-018 SHALL honour macro LAT_MEMORY_BYTE_EN: defined -> only bytes with req_be[i]=1 are written; undefined -> req_be ignored, full word written.

Structure
REQ-019 SHALL place state enum lat_mem_state_e (IDLE, BUSY, RESP) and request struct lat_mem_req_t in shared package mem_pkg.
REQ-020 SHALL place the storage array in sub-module mem_array (synchronous write with per-byte enable, registered read).

Verification
REQ-021 Reset then write addr 0x10, data 0xDEADBEEF, tag 3 -> resp_valid exactly 3 cycles later, resp_tag 3, resp_err 0, rdata 0.
REQ-022 Read addr 0x10 tag 5 after REQ-021 -> resp_rdata 0xDEADBEEF, tag 5, 3-cycle latency.
REQ-023 With LAT_MEMORY_BYTE_EN: write 0x11223344 be 4'b0011 to 0x10 over 0xDEADBEEF -> read returns 0xDEAD3344; without macro -> 0x11223344.
REQ-024 Read addr 0x1002 and addr 0x1000 (MEM_SIZE 1024) -> both resp_err 1, rdata 0, no array change.
REQ-025 Hold resp_ready 0 for 5 cycles -> response stable, req_ready 0 throughout; release -> IDLE next edge.
REQ-026 Assert rst_n low 1 cycle after accepting a write to 0x20 -> resp_valid stays 0, read of 0x20 after reset does not return new data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for lat_memory: FSM state encoding and the latched request record.
// The request record is sized for the widest supported configuration; narrower builds use the low bits.
package mem_pkg;

    localparam int unsigned LM_MAX_XLEN  = 64;
    localparam int unsigned LM_MAX_TAG_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } lat_mem_state_e;

    typedef struct packed {
        logic                       write;
        logic [LM_MAX_XLEN-1:0]     addr;
        logic [LM_MAX_XLEN-1:0]     wdata;
        logic [LM_MAX_XLEN/8-1:0]   be;
        logic [LM_MAX_TAG_W-1:0]    tag;
    } lat_mem_req_t;

endpackage

// File: rtl/mem_array.sv
// Word-organised storage: synchronous per-byte write, registered read.
// Contents are intentionally not reset.
module mem_array #(
    parameter  int XLEN  = 32,
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic                i_re,
    input  logic [AW-1:0]       i_idx,
    input  logic [XLEN-1:0]     i_wdata,
    input  logic [XLEN/8-1:0]   i_be,
    output logic [XLEN-1:0]     o_rdata
);

    logic [XLEN-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < XLEN/8; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
        if (i_re) begin
            o_rdata <= r_mem[i_idx];
        end
    end

endmodule

// File: rtl/lat_memory.sv
// Single-outstanding memory with fixed request-to-response latency (IDLE -> BUSY -> RESP).
// Macro LAT_MEMORY_BYTE_EN: defined -> req_be masks written bytes; undefined -> whole word written.
module lat_memory
    import mem_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MEM_SIZE = 1024,
    parameter int LATENCY  = 3,
    parameter int TAG_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    input  logic [XLEN/8-1:0]   req_be,
    input  logic [TAG_W-1:0]    req_tag,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_rdata,
    output logic [TAG_W-1:0]    resp_tag,
    output logic                resp_err,
    output lat_mem_state_e      o_dbg_state
);

    localparam int IDX_W  = $clog2(MEM_SIZE);
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int NBYTES = XLEN / 8;

    lat_mem_state_e     r_state;
    logic [CNT_W-1:0]   r_cnt;
    lat_mem_req_t       r_req;
    logic               r_req_ready;
    logic               r_resp_valid;
    logic               r_resp_err;
    logic               r_rd_ok;
    logic [TAG_W-1:0]   r_resp_tag;

    lat_mem_req_t       w_in;
    lat_mem_req_t       w_cur;
    logic               w_accept;
    logic               w_enter_resp;
    logic               w_err;
    logic               w_we;
    logic               w_re;
    logic [XLEN-1:0]    w_addr;
    logic [XLEN-1:0]    w_rdata;
    logic [NBYTES-1:0]  w_be;
    logic [IDX_W-1:0]   w_idx;

    always_comb begin
        w_in                   = '0;
        w_in.write             = req_write;
        w_in.addr[XLEN-1:0]    = req_addr;
        w_in.wdata[XLEN-1:0]   = req_wdata;
        w_in.be[NBYTES-1:0]    = req_be;
        w_in.tag[TAG_W-1:0]    = req_tag;
    end

    // With LATENCY==1 the array is accessed on the acceptance edge, so decode the live inputs in IDLE.
    assign w_accept     = req_valid && r_req_ready;
    assign w_cur        = (r_state == IDLE) ? w_in : r_req;
    assign w_addr       = w_cur.addr[XLEN-1:0];
    assign w_idx        = w_addr[IDX_W+1:2];
    assign w_err        = (w_addr[1:0] != 2'b00) ||
                          ({1'b0, w_addr} >= (XLEN+1)'(MEM_SIZE * 4));
    assign w_enter_resp = (r_state == IDLE) ? (w_accept && (LATENCY == 1))
                                            : ((r_state == BUSY) && (r_cnt == '0));
    assign w_we         = w_enter_resp && w_cur.write && !w_err;
    assign w_re         = w_enter_resp && !w_cur.write && !w_err;

`ifdef LAT_MEMORY_BYTE_EN
    assign w_be = w_cur.be[NBYTES-1:0];
`else
    assign w_be = '1;
`endif

    mem_array #(
        .XLEN   (XLEN),
        .DEPTH  (MEM_SIZE)
    ) u_mem_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_idx   (w_idx),
        .i_wdata (w_cur.wdata[XLEN-1:0]),
        .i_be    (w_be),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_req        <= '0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rd_ok      <= 1'b0;
            r_resp_tag   <= '0;
        end else begin
            if (w_enter_resp) begin
                r_state      <= RESP;
                r_resp_valid <= 1'b1;
                r_resp_err   <= w_err;
                r_rd_ok      <= !w_err && !w_cur.write;
                r_resp_tag   <= w_cur.tag[TAG_W-1:0];
            end
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req       <= w_in;
                        r_req_ready <= 1'b0;
                        if (LATENCY > 1) begin
                            r_state <= BUSY;
                            r_cnt   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state      <= IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Read data is gated so writes, errors and reset all present zero.
    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_rd_ok ? w_rdata : '0;
    assign resp_tag    = r_resp_tag;
    assign resp_err    = r_resp_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lat_memory.sv
// Bench for lat_memory: directed scenarios plus randomized traffic against a word-level array model.
`timescale 1ns/1ps
module tb_lat_memory;
    import mem_pkg::*;

    localparam int XLEN     = 32;
    localparam int MEM_SIZE = 1024;
    localparam int LATENCY  = 3;
    localparam int TAG_W    = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic               req_valid = 1'b0;
    logic               req_ready;
    logic               req_write = 1'b0;
    logic [XLEN-1:0]    req_addr  = '0;
    logic [XLEN-1:0]    req_wdata = '0;
    logic [XLEN/8-1:0]  req_be    = '0;
    logic [TAG_W-1:0]   req_tag   = '0;
    logic               resp_valid;
    logic               resp_ready = 1'b0;
    logic [XLEN-1:0]    resp_rdata;
    logic [TAG_W-1:0]   resp_tag;
    logic               resp_err;
    lat_mem_state_e     dbg_state;

    lat_memory #(
        .XLEN     (XLEN),
        .MEM_SIZE (MEM_SIZE),
        .LATENCY  (LATENCY),
        .TAG_W    (TAG_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_be      (req_be),
        .req_tag     (req_tag),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_tag    (resp_tag),
        .resp_err    (resp_err),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [XLEN-1:0] model_mem [int];
    logic [XLEN-1:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic model_err(input logic [XLEN-1:0] addr);
        return (addr % 4 != 0) || (addr >= MEM_SIZE * 4);
    endfunction

    // ---------------- driver ----------------
    // Called and returns at 1ns after a rising edge.
    task automatic do_txn(input logic wr, input logic [XLEN-1:0] addr, input logic [XLEN-1:0] wdata,
                          input logic [3:0] be, input logic [TAG_W-1:0] tag, input int hold);
        logic            e_err;
        logic            e_known;
        logic [XLEN-1:0] e_rd;
        logic [XLEN-1:0] m;
        int              idx;
        int              w;
        int              lat;

        e_err = model_err(addr);
        idx   = int'(addr >> 2);
        if (e_err || wr) begin
            e_rd = '0; e_known = 1'b1;
        end else if (model_mem.exists(idx)) begin
            e_rd = model_mem[idx]; e_known = 1'b1;
        end else begin
            e_rd = '0; e_known = 1'b0;
        end

        req_valid = 1'b1; req_write = wr; req_addr = addr;
        req_wdata = wdata; req_be = be; req_tag = tag;
        w = 0;
        while (!req_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        exp_q.push_back(e_rd);
        if (wr && !e_err) begin
`ifdef LAT_MEMORY_BYTE_EN
            if (model_mem.exists(idx)) begin
                m = model_mem[idx];
                for (int b = 0; b < 4; b++) if (be[b]) m[b*8 +: 8] = wdata[b*8 +: 8];
                model_mem[idx] = m;
            end else if (be == 4'hF) begin
                model_mem[idx] = wdata;
            end
`else
            m = wdata;
            model_mem[idx] = m;
`endif
        end

        // Garbage on the request bus while the request is in flight.
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom; req_wdata = $urandom;
        req_be    = 4'($urandom); req_tag = TAG_W'($urandom);

        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        e_rd = exp_q.pop_front();
        check("latency", lat, LATENCY);
        if (!resp_valid) begin
            req_valid = 1'b0;
            return;
        end
        for (int h = 0; h <= hold; h++) begin
            check("resp_valid", resp_valid, 1);
            check("req_ready_in_resp", req_ready, 0);
            check("resp_tag", resp_tag, tag);
            check("resp_err", resp_err, e_err);
            if (e_known) check("resp_rdata", resp_rdata, e_rd);
            if (h < hold) begin
                @(posedge clk); #1;
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("resp_valid_after_hs", resp_valid, 0);
        check("req_ready_after_hs", req_ready, 1);
        check("state_after_hs", dbg_state, IDLE);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_tag", resp_tag, 0);
        check("rst_resp_err", resp_err, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("req_ready_before_edge", req_ready, 0);
        @(posedge clk); #1;
        check("req_ready_after_rst", req_ready, 1);

        // Basic write then read-back.
        do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 4'd3, 0);
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, 4'd5, 0);
        // Partial byte-enable write.
        do_txn(1'b1, 32'h10, 32'h11223344, 4'b0011, 4'd6, 1);
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, 4'd7, 0);
`ifdef LAT_MEMORY_BYTE_EN
        check("be_merge_model", model_mem[4], 32'hDEAD3344);
`else
        check("be_ignored_model", model_mem[4], 32'h11223344);
`endif
        // Error requests: misaligned and out of range, neither touches the array.
        do_txn(1'b0, 32'h1002, 32'h0, 4'hF, 4'd8, 0);
        do_txn(1'b0, 32'h1000, 32'h0, 4'hF, 4'd9, 0);
        do_txn(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 4'd1, 0);
        do_txn(1'b1, 32'h1000, 32'hBAD0BAD0, 4'hF, 4'd2, 0);
        do_txn(1'b1, 32'h12, 32'hBAD1BAD1, 4'hF, 4'd4, 0);
        do_txn(1'b0, 32'h0, 32'h0, 4'hF, 4'd10, 0);
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, 4'd11, 0);
        // Back-pressure for 5 cycles.
        do_txn(1'b0, 32'h0, 32'h0, 4'hF, 4'd12, 5);

        // Reset one cycle into an in-flight write: the write must not land.
        do_txn(1'b1, 32'h20, 32'hA5A50F0F, 4'hF, 4'd13, 0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
        req_wdata = 32'h12345678; req_be = 4'hF; req_tag = 4'd14;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_resp_valid", resp_valid, 0);
        check("abort_req_ready", req_ready, 0);
        check("abort_state", dbg_state, IDLE);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("abort_no_resp", resp_valid, 0);
        end
        do_txn(1'b0, 32'h20, 32'h0, 4'hF, 4'd15, 0);

        // Randomized traffic over a small word pool plus occasional wild addresses.
        for (int t = 0; t < 60; t++) begin
            logic [XLEN-1:0] a;
            if ($urandom_range(0, 9) < 8) a = XLEN'($urandom_range(0, 31)) << 2;
            else if ($urandom_range(0, 1) == 1) a = XLEN'($urandom_range(0, 4095));
            else a = $urandom;
            do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), TAG_W'($urandom),
                   $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
